// File: rtl/irq_pend_pkg.sv
// -----------------------------------------------------------------------------
// irq_pend_pkg
// Shared definitions for the interrupt request-capture stage:
//   - IRQ_N / IRQ_IDX_W : default request-line count and index width
//   - irq_state_e       : grant FSM state encoding
// -----------------------------------------------------------------------------
package irq_pend_pkg;

    localparam int IRQ_N     = 4;
    localparam int IRQ_IDX_W = $clog2(IRQ_N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } irq_state_e;

endpackage : irq_pend_pkg

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational highest-set-bit encoder; bit N-1 has the highest priority.
// Ports:
//   in_i  [N]      candidate lines
//   idx_o [IDX_W]  index of the highest set bit (0 when none set)
//   any_o          at least one bit of in_i is set
// -----------------------------------------------------------------------------
module irq_prio_enc
    import irq_pend_pkg::*;
#(
    parameter int N     = IRQ_N,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     in_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Ascending scan: the last set bit visited (the highest) wins.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (in_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign any_o = |in_i;

endmodule : irq_prio_enc

// File: rtl/irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// irq_pending_ctrl
// Request-capture stage: rising-edge detect on level request lines, sticky
// pending register, registered highest-priority grant with valid/ack
// handshake, and sticky per-line overflow flags for requests re-raised while
// still pending.
//
// Optional feature: define IRQ_PEND_MASK_EN to add the mask port. Masked lines
// still latch pend/ovf but are never granted and do not count in any_pend.
//
// Ports:
//   clk       clock, all state on the rising edge
//   rst       synchronous active-high reset
//   req_in    [N] level request lines (synchronous to clk)
//   mask      [N] 1 = line not eligible (IRQ_PEND_MASK_EN only)
//   ack       consumer accepts the current grant (ignored while valid=0)
//   ovf_clr   clears all overflow flags
//   valid     grant presented on idx
//   idx       [IDX_W] granted line index, frozen while valid=1
//   any_pend  registered OR of eligible pending bits
//   pend      [N] pending register
//   ovf       [N] sticky overflow flags
// -----------------------------------------------------------------------------
module irq_pending_ctrl
    import irq_pend_pkg::*;
#(
    parameter int N     = IRQ_N,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_in,
`ifdef IRQ_PEND_MASK_EN
    input  logic [N-1:0]     mask,
`endif
    input  logic             ack,
    input  logic             ovf_clr,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic             any_pend,
    output logic [N-1:0]     pend,
    output logic [N-1:0]     ovf
);

    irq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     req_q;
    logic [N-1:0]     pend_q, pend_d;
    logic [N-1:0]     ovf_q, ovf_d;
    logic             any_pend_q;

    logic [N-1:0]     rise;
    logic [N-1:0]     clr;
    logic [N-1:0]     elig;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

`ifdef IRQ_PEND_MASK_EN
    assign elig = pend_q & ~mask;
`else
    assign elig = pend_q;
`endif

    irq_prio_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_enc (
        .in_i  (elig),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    // Grant FSM. idx is captured only on the IDLE->GRANT transition so it
    // cannot move under a live grant.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    state_d = GRANT;
                    idx_d   = enc_idx;
                end
            end
            GRANT: begin
                if (ack) begin
                    state_d    = IDLE;
                    clr[idx_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending/overflow next state. A rise on the bit being cleared this cycle
    // re-arms it without counting as an overflow; a fresh overflow survives a
    // coincident ovf_clr.
    always_comb begin
        rise   = req_in & ~req_q;
        pend_d = (pend_q & ~clr) | rise;
        ovf_d  = (ovf_clr ? '0 : ovf_q) | (rise & pend_q & ~clr);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: req_q deliberately tracks req_in during reset too, so a line
        // already high at reset release is not mistaken for a new edge.
        req_q <= req_in;
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pend_q     <= '0;
            ovf_q      <= '0;
            any_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            any_pend_q <= |elig;
        end
    end

    assign valid    = (state_q == GRANT);
    assign idx      = idx_q;
    assign any_pend = any_pend_q;
    assign pend     = pend_q;
    assign ovf      = ovf_q;

endmodule : irq_pending_ctrl
